multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequential control unit for the multicycle ARM core.
- Replaces the single-cycle combinational decode/ALU-decode path with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles against a shared instruction/data memory.
- Adds a memory-ready handshake, a parametrised multi-cycle multiply state, and condition-gated writes.
- Sits between the instruction register/condition unit and the multicycle datapath.

Parameters:
- MUL_LATENCY, 2, cycles spent in MULT state (legal range 1..15).
- CNT_W, 4, width of the multiply cycle counter (must hold MUL_LATENCY-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  2  instruction class, instr[27:26].
- funct  in  6  instr[25:20] (I, cmd[3:0], S/L).
- instr74  in  4  instr[7:4]; 4'b1001 marks multiply.
- rd  in  4  destination register.
- cond_ex  in  1  condition check passed (from condition unit).
- mem_ready  in  1  memory completes access this cycle.
- ir_w  out  1  instruction register write.
- pc_w  out  1  PC write.
- adr_src  out  1  0 = PC, 1 = result bus.
- reg_w  out  1  register file write.
- mem_w  out  1  memory write.
- alu_src_a  out  1  0 = RD1, 1 = PC.
- alu_src_b  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
- result_src  out  2  00 = ALUOut reg, 01 = Data reg, 10 = ALU result.
- alu_ctl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL.
- flag_w  out  2  [1] = NZ write, [0] = CV write.
- imm_src  out  2  equals op.
- reg_src  out  2  [0] = (op==10), [1] = (op==01).
- state  out  4  current state encoding, for debug and verification.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, MULT=10. Encodings 11..15 are unused and go to FETCH next cycle.
- Reset (asynchronous): state=FETCH, multiply counter=0. All outputs take their FETCH decode with mem_ready=0: ir_w=pc_w=0, adr_src=0, alu_src_a=1, alu_src_b=10, alu_ctl=000, result_src=10, all write enables 0. imm_src and reg_src are combinational from op.
- Outputs are combinational from state and the instruction fields only (Moore plus field decode). The only input-dependent strobes are mem_ready and cond_ex.
- Instruction classes:
  - multiply: op=00, funct[5:4]=00, instr74=1001.
  - data-processing: op=00, not multiply.
  - memory: op=01.
  - branch: op=10.
  - op=11: DECODE returns to FETCH, no writes.
- FETCH:
  - adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - ir_w=pc_w=mem_ready. Hold in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10 (PC+8 read path). Next state:
  - MEMADR for memory.
  - EXECI if funct[5]=1, else EXECR, for data-processing.
  - MULT for multiply.
  - BRANCH for branch.
- MEMADR: alu_src_a=0, alu_src_b=01, ADD. Next is MEMRD if funct[0]=1, else MEMWR.
- MEMRD: adr_src=1. Hold until mem_ready, then go to MEMWB.
- MEMWR: adr_src=1, mem_w=cond_ex. Hold until mem_ready, then go to FETCH. mem_w is asserted only while in MEMWR.
- MEMWB and ALUWB:
  - result_src=01 in MEMWB, 00 in ALUWB.
  - If cond_ex and rd==15: pc_w=1, reg_w=0. Else reg_w=cond_ex.
  - Next is FETCH.
- EXECR and EXECI:
  - alu_src_a=0; alu_src_b=00 (EXECR) or 01 (EXECI).
  - cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP→SUB, 1000 TST→AND; others ADD.
  - flag_w[1]=S & cond_ex; flag_w[0]=S & cond_ex & cmd∈{ADD,SUB,CMP}. CMP and TST force S behaviour.
  - Next is FETCH for CMP/TST (no writeback), else ALUWB.
- MULT:
  - alu_ctl=100, alu_src_a=0, alu_src_b=00.
  - The counter increments each cycle. When it reaches MUL_LATENCY-1: clear it, go to ALUWB, and assert flag_w[1]=S & cond_ex on that final cycle only.
- BRANCH: alu_src_a=0, alu_src_b=01, ADD, result_src=10, pc_w=cond_ex. Next is FETCH.
- cond_ex=0 still walks the full state sequence but suppresses reg_w, mem_w, flag_w and the branch/writeback pc_w. Fetch pc_w is never gated.
- Reset asserted mid-instruction (including during MULT or a memory wait) aborts immediately: state=FETCH, counter=0.

Test Plan:
- Reset, then release with mem_ready=0 → state=0 for 3 cycles, ir_w=pc_w=0; raise mem_ready → ir_w=pc_w=1 that cycle, state=1 next.
- ADD reg (op=00, funct=001000, rd=3, cond_ex=1) → FETCH, DECODE, EXECR (alu_ctl=000), ALUWB (reg_w=1, result_src=00), then FETCH.
- LDR (op=01, funct=011001) with mem_ready low 2 cycles in MEMRD → MEMRD held 3 cycles with adr_src=1; MEMWB result_src=01, reg_w=1. Repeat with rd=15 → pc_w=1, reg_w=0.
- STR with cond_ex=0 → MEMWR reached, mem_w=0 throughout, returns to FETCH after mem_ready.
- MUL with MUL_LATENCY=3, S=1 → exactly 3 MULT cycles with alu_ctl=100, flag_w=10 only on the 3rd, then ALUWB. Assert reset on the 2nd MULT cycle in a separate run → state=0 immediately, next MUL again takes 3 cycles.
- CMP (cmd=1010, funct=010101) → EXECR with alu_ctl=001, flag_w=11, then FETCH (no ALUWB). Branch with cond_ex=1 → BRANCH pc_w=1. op=11 → DECODE then FETCH, no writes.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the instruction register/condition unit, the
// multicycle controller and the multicycle datapath.
interface multicycle_controller_if;
  // Instruction fields and status from the decode side
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] instr74;
  logic [3:0] rd;
  logic       cond_ex;
  logic       mem_ready;

  // Datapath controls
  logic       ir_w;
  logic       pc_w;
  logic       adr_src;
  logic       reg_w;
  logic       mem_w;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] alu_ctl;
  logic [1:0] flag_w;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [3:0] state;

  // Memory handshake: the controller presents an access (adr_src selects
  // the address) while in FETCH, MEMRD or MEMWR; the access completes in
  // the cycle mem_ready is high, and the controller holds its state and
  // outputs until that cycle. mem_ready may be high in any cycle; it is
  // only consumed in those three states.
  modport master (
    input  op, funct, instr74, rd, cond_ex, mem_ready,
    output ir_w, pc_w, adr_src, reg_w, mem_w, alu_src_a, alu_src_b,
           result_src, alu_ctl, flag_w, imm_src, reg_src, state
  );

  modport slave (
    output op, funct, instr74, rd, cond_ex, mem_ready,
    input  ir_w, pc_w, adr_src, reg_w, mem_w, alu_src_a, alu_src_b,
           result_src, alu_ctl, flag_w, imm_src, reg_src, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle ARM core: sequences fetch, decode,
// execute, memory and writeback, with a multi-cycle multiply state.
module multicycle_controller #(
  parameter int MUL_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    MULT   = 4'd10
  } state_t;

  localparam logic [CNT_W-1:0] mul_last = CNT_W'(MUL_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       is_mul;
  logic [3:0] cmd;
  logic       is_cmp_tst;
  logic       s_eff;
  logic       dp_cv;
  logic [2:0] dp_alu;
  logic       mul_done;

  assign is_mul     = (bus.op == 2'b00) && (bus.funct[5:4] == 2'b00) &&
                      (bus.instr74 == 4'b1001);
  assign cmd        = bus.funct[4:1];
  assign is_cmp_tst = (cmd == 4'b1010) || (cmd == 4'b1000);
  assign s_eff      = bus.funct[0] | is_cmp_tst;
  assign dp_cv      = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
  assign mul_done   = (cnt_q == mul_last);

  always_comb begin
    dp_alu = 3'b000;
    case (cmd)
      4'b0010: dp_alu = 3'b001;
      4'b1010: dp_alu = 3'b001;
      4'b0000: dp_alu = 3'b010;
      4'b1000: dp_alu = 3'b010;
      4'b1100: dp_alu = 3'b011;
      default: dp_alu = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Defaults are the FETCH datapath setting (PC + 4 on the ALU, no writes)
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus.ir_w       = 1'b0;
    bus.pc_w       = 1'b0;
    bus.adr_src    = 1'b0;
    bus.reg_w      = 1'b0;
    bus.mem_w      = 1'b0;
    bus.alu_src_a  = 1'b1;
    bus.alu_src_b  = 2'b10;
    bus.result_src = 2'b10;
    bus.alu_ctl    = 3'b000;
    bus.flag_w     = 2'b00;

    case (state_q)
      FETCH: begin
        bus.ir_w = bus.mem_ready;
        bus.pc_w = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        case (bus.op)
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          2'b00:   state_d = is_mul ? MULT : (bus.funct[5] ? EXECI : EXECR);
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b01;
        state_d       = bus.funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWR: begin
        bus.adr_src = 1'b1;
        bus.mem_w   = bus.cond_ex;
        if (bus.mem_ready) state_d = FETCH;
      end
      MEMWB, ALUWB: begin
        bus.result_src = (state_q == MEMWB) ? 2'b01 : 2'b00;
        // A write to r15 is a jump: it lands in the PC, not the register file
        if (bus.cond_ex && (bus.rd == 4'hf)) bus.pc_w = 1'b1;
        else bus.reg_w = bus.cond_ex;
        state_d = FETCH;
      end
      EXECR, EXECI: begin
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = (state_q == EXECI) ? 2'b01 : 2'b00;
        bus.alu_ctl   = dp_alu;
        bus.flag_w    = {s_eff & bus.cond_ex, s_eff & bus.cond_ex & dp_cv};
        state_d       = is_cmp_tst ? FETCH : ALUWB;
      end
      MULT: begin
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b00;
        bus.alu_ctl   = 3'b100;
        if (mul_done) begin
          cnt_d      = '0;
          bus.flag_w = {bus.funct[0] & bus.cond_ex, 1'b0};
          state_d    = ALUWB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BRANCH: begin
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b01;
        bus.pc_w      = bus.cond_ex;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.imm_src = bus.op;
  assign bus.reg_src = {bus.op == 2'b01, bus.op == 2'b10};
  assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver queues the expected
// control word for each cycle, a monitor compares it mid-cycle.
module tb_multicycle_controller;
  localparam int W = 23;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if bus();

  multicycle_controller #(.MUL_LATENCY(3), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  logic [1:0] n_op;
  logic [5:0] n_funct;
  logic [3:0] n_i74;
  logic [3:0] n_rd;
  logic       n_cond;

  function automatic logic [W-1:0] obs();
    return {bus.state, bus.ir_w, bus.pc_w, bus.adr_src, bus.reg_w, bus.mem_w,
            bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctl,
            bus.flag_w, bus.imm_src, bus.reg_src};
  endfunction

  function automatic logic [W-1:0] ex(input logic [3:0] st, input logic irw,
      input logic pcw, input logic adr, input logic regw, input logic memw,
      input logic sa, input logic [1:0] sb, input logic [1:0] rs,
      input logic [2:0] alu, input logic [1:0] fw);
    logic [1:0] rsrc;
    rsrc = {n_op == 2'b01, n_op == 2'b10};
    return {st, irw, pcw, adr, regw, memw, sa, sb, rs, alu, fw, n_op, rsrc};
  endfunction

  // ---------------- driver ----------------
  task automatic load(input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] i74, input logic [3:0] r, input logic c);
    n_op = o; n_funct = f; n_i74 = i74; n_rd = r; n_cond = c;
  endtask

  task automatic step(input string nm, input logic mr, input logic rst_in,
                      input logic [W-1:0] e);
    @(negedge clk);
    reset         = rst_in;
    bus.mem_ready = mr;
    bus.op        = n_op;
    bus.funct     = n_funct;
    bus.instr74   = n_i74;
    bus.rd        = n_rd;
    bus.cond_ex   = n_cond;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic t_fetch(input logic mr);
    step("fetch", mr, 1'b0, ex(4'd0, mr, mr, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, 2'b00));
  endtask
  task automatic t_decode();
    step("decode", 1'b0, 1'b0, ex(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, 2'b00));
  endtask
  task automatic t_memadr();
    step("memadr", 1'b0, 1'b0, ex(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00));
  endtask
  task automatic t_memrd(input logic mr);
    step("memrd", mr, 1'b0, ex(4'd3, 0, 0, 1, 0, 0, 1, 2'b10, 2'b10, 3'b000, 2'b00));
  endtask
  task automatic t_memwr(input logic mr, input logic memw);
    step("memwr", mr, 1'b0, ex(4'd5, 0, 0, 1, 0, memw, 1, 2'b10, 2'b10, 3'b000, 2'b00));
  endtask
  task automatic t_memwb(input logic regw, input logic pcw);
    step("memwb", 1'b0, 1'b0, ex(4'd4, 0, pcw, 0, regw, 0, 1, 2'b10, 2'b01, 3'b000, 2'b00));
  endtask
  task automatic t_exec(input logic [3:0] st, input logic [1:0] sb,
                        input logic [2:0] alu, input logic [1:0] fw);
    step("exec", 1'b0, 1'b0, ex(st, 0, 0, 0, 0, 0, 0, sb, 2'b10, alu, fw));
  endtask
  task automatic t_aluwb(input logic regw, input logic pcw);
    step("aluwb", 1'b0, 1'b0, ex(4'd8, 0, pcw, 0, regw, 0, 1, 2'b10, 2'b00, 3'b000, 2'b00));
  endtask
  task automatic t_branch(input logic pcw);
    step("branch", 1'b0, 1'b0, ex(4'd9, 0, pcw, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00));
  endtask
  task automatic t_mult(input logic [1:0] fw);
    step("mult", 1'b0, 1'b0, ex(4'd10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b100, fw));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    @(negedge clk);
    #3;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = obs();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got %b expected %b", nm, $time, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.op        = 2'b00;
    bus.funct     = 6'b0;
    bus.instr74   = 4'b0;
    bus.rd        = 4'b0;
    bus.cond_ex   = 1'b0;

    // Reset, then release with memory not ready; ADD r3 register form
    load(2'b00, 6'b001000, 4'b0000, 4'd3, 1'b1);
    step("reset", 1'b0, 1'b1, ex(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, 2'b00));
    repeat (3) t_fetch(1'b0);
    t_fetch(1'b1);
    t_decode();
    t_exec(4'd6, 2'b00, 3'b000, 2'b00);
    t_aluwb(1'b1, 1'b0);

    // LDR r2 with two wait cycles, then LDR r15
    load(2'b01, 6'b011001, 4'b0000, 4'd2, 1'b1);
    t_fetch(1'b1); t_decode(); t_memadr();
    t_memrd(1'b0); t_memrd(1'b0); t_memrd(1'b1);
    t_memwb(1'b1, 1'b0);
    load(2'b01, 6'b011001, 4'b0000, 4'd15, 1'b1);
    t_fetch(1'b1); t_decode(); t_memadr(); t_memrd(1'b1);
    t_memwb(1'b0, 1'b1);

    // STR with failing condition
    load(2'b01, 6'b011000, 4'b0000, 4'd1, 1'b0);
    t_fetch(1'b1); t_decode(); t_memadr();
    t_memwr(1'b0, 1'b0); t_memwr(1'b1, 1'b0);

    // STR with passing condition
    load(2'b01, 6'b011000, 4'b0000, 4'd1, 1'b1);
    t_fetch(1'b1); t_decode(); t_memadr(); t_memwr(1'b1, 1'b1);

    // MULS r4, latency 3
    load(2'b00, 6'b000001, 4'b1001, 4'd4, 1'b1);
    t_fetch(1'b1); t_decode();
    t_mult(2'b00); t_mult(2'b00); t_mult(2'b10);
    t_aluwb(1'b1, 1'b0);

    // Reset landing on the second MULT cycle, then a full MULS again
    t_fetch(1'b1); t_decode(); t_mult(2'b00);
    step("mult_reset", 1'b0, 1'b1, ex(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, 2'b00));
    t_fetch(1'b0);
    t_fetch(1'b1); t_decode();
    t_mult(2'b00); t_mult(2'b00); t_mult(2'b10);
    t_aluwb(1'b1, 1'b0);

    // CMP: SUB with both flag groups, no writeback
    load(2'b00, 6'b010101, 4'b0000, 4'd0, 1'b1);
    t_fetch(1'b1); t_decode();
    t_exec(4'd6, 2'b00, 3'b001, 2'b11);

    // ORRS immediate with failing condition: no flags, no write
    load(2'b00, 6'b111001, 4'b0000, 4'd5, 1'b0);
    t_fetch(1'b1); t_decode();
    t_exec(4'd7, 2'b01, 3'b011, 2'b00);
    t_aluwb(1'b0, 1'b0);

    // Branch taken
    load(2'b10, 6'b101000, 4'b0000, 4'd0, 1'b1);
    t_fetch(1'b1); t_decode(); t_branch(1'b1);

    // op=11: decode straight back to fetch
    load(2'b11, 6'b000000, 4'b0000, 4'd0, 1'b1);
    t_fetch(1'b1); t_decode();
    t_fetch(1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
